// File: rtl/io_bus_pkg.sv
// Shared types and constants for the io_bus_master req/ack initiator.
package io_bus_pkg;

   localparam int unsigned MIN_SYNC_STAGES = 2;

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      WAIT_LOW,
      DRAIN,
      RESP
   } state_t;

   // Phase counter must hold TIMEOUT_CYCLES itself; never narrower than one bit.
   function automatic int unsigned cnt_width(input int unsigned timeout_cycles);
      return (timeout_cycles == 0) ? 1 : $clog2(timeout_cycles + 1);
   endfunction

endpackage

// File: rtl/io_bus_master_if.sv
// Bus side of the 4-phase req/ack chain between initiator and responder.
interface io_bus_master_if #(
   parameter int unsigned ADDR_WIDTH = 8
);
   logic [ADDR_WIDTH-1:0] address;
   logic                  write;
   logic                  data_out;
   logic                  req_next;
   logic                  data_in;
   logic                  ack_next;

   modport master (
      output address, write, data_out, req_next,
      input  data_in, ack_next
   );

   modport slave (
      input  address, write, data_out, req_next,
      output data_in, ack_next
   );
endinterface

// File: rtl/io_bus_master_bit_sync.sv
// Multi-flop synchroniser for a single asynchronous level, cleared on reset.
module bit_sync #(
   parameter int unsigned STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic i_d,
   output logic o_q
);
   logic [STAGES-1:0] r_sync;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_sync <= '0;
      end else begin
         r_sync <= {r_sync[STAGES-2:0], i_d};
      end
   end

   assign o_q = r_sync[STAGES-1];
endmodule

// File: rtl/io_bus_master.sv
// Initiator for single-bit read/write transfers over the 4-phase req/ack bus,
// with per-phase timeout and stale-ack protection.
module io_bus_master
   import io_bus_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH     = 8,
   parameter int unsigned SYNC_STAGES    = 2,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_write,
   input  logic [ADDR_WIDTH-1:0] cmd_address,
   input  logic                  cmd_data,
   output logic                  rsp_valid,
   output logic                  rsp_data,
   output logic                  rsp_error,
   io_bus_master_if.master       bus
);
   typedef struct packed {
      logic                  write;
      logic [ADDR_WIDTH-1:0] address;
      logic                  data;
   } bus_cmd_t;

   localparam int unsigned SYNC_N = (SYNC_STAGES < MIN_SYNC_STAGES) ? MIN_SYNC_STAGES : SYNC_STAGES;
   localparam int unsigned CNT_W  = cnt_width(TIMEOUT_CYCLES);
   localparam bit          TO_EN  = (TIMEOUT_CYCLES != 0);
   localparam logic [CNT_W-1:0] CNT_LAST = TO_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

   state_t           r_state;
   bus_cmd_t         r_cmd;
   logic             r_req;
   logic             r_rd;
   logic             r_err;
   logic             r_rsp_valid;
   logic             r_rsp_data;
   logic             r_rsp_error;
   logic [CNT_W-1:0] r_cnt;
   logic             w_ack_s;
   logic             w_timeout;

   bit_sync #(.STAGES(SYNC_N)) u_ack_sync (
      .clk   (clk),
      .reset (reset),
      .i_d   (bus.ack_next),
      .o_q   (w_ack_s)
   );

   assign w_timeout = TO_EN && (r_cnt == CNT_LAST);
   // A still-high synchronised ack from an aborted transfer must drain before a new request.
   assign cmd_ready = (r_state == IDLE) && !w_ack_s && !reset;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= IDLE;
         r_cmd       <= '0;
         r_req       <= 1'b0;
         r_rd        <= 1'b0;
         r_err       <= 1'b0;
         r_rsp_valid <= 1'b0;
         r_rsp_data  <= 1'b0;
         r_rsp_error <= 1'b0;
         r_cnt       <= '0;
      end else begin
         r_rsp_valid <= 1'b0;
         r_rsp_data  <= 1'b0;
         r_rsp_error <= 1'b0;
         if (r_cnt != '1) r_cnt <= r_cnt + 1'b1;
         case (r_state)
            IDLE: begin
               if (cmd_valid && !w_ack_s) begin
                  r_cmd.write   <= cmd_write;
                  r_cmd.address <= cmd_address;
                  r_cmd.data    <= cmd_data;
                  r_req         <= 1'b1;
                  r_cnt         <= '0;
                  r_state       <= REQ;
               end
            end
            REQ: begin
               if (w_ack_s) begin
                  if (!r_cmd.write) r_rd <= bus.data_in;
                  r_req   <= 1'b0;
                  r_cnt   <= '0;
                  r_state <= WAIT_LOW;
               end else if (w_timeout) begin
                  r_req   <= 1'b0;
                  r_err   <= 1'b1;
                  r_state <= DRAIN;
               end
            end
            WAIT_LOW: begin
               if (!w_ack_s) begin
                  r_rsp_valid <= 1'b1;
                  r_rsp_data  <= r_rd & ~r_cmd.write & ~r_err;
                  r_rsp_error <= r_err;
                  r_state     <= RESP;
               end else if (w_timeout) begin
                  r_err   <= 1'b1;
                  r_state <= DRAIN;
               end
            end
            DRAIN: begin
               if (!w_ack_s) begin
                  r_rsp_valid <= 1'b1;
                  r_rsp_data  <= r_rd & ~r_cmd.write & ~r_err;
                  r_rsp_error <= r_err;
                  r_state     <= RESP;
               end
            end
            RESP: begin
               r_rd    <= 1'b0;
               r_err   <= 1'b0;
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign rsp_valid    = r_rsp_valid;
   assign rsp_data     = r_rsp_data;
   assign rsp_error    = r_rsp_error;
   assign bus.address  = r_cmd.address;
   assign bus.write    = r_cmd.write;
   assign bus.data_out = r_cmd.data;
   assign bus.req_next = r_req;
endmodule
